// File: rtl/ecc_encode_inject_if.sv
// Stream bundle between the word source, the ECC encoder/injector and the SECDED checker.
// The master drives words in and takes encoded words out; the slave is the encoder.
interface ecc_encode_inject_if #(
  parameter int DW = 64
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] data_in;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] data_out;
  logic [7:0]    ecc_out;

  modport master (
    output in_valid, data_in, out_ready,
    input  in_ready, out_valid, data_out, ecc_out
  );

  modport slave (
    input  in_valid, data_in, out_ready,
    output in_ready, out_valid, data_out, ecc_out
  );
endinterface

// File: rtl/ecc_encode_inject.sv
// SECDED (72,64) encoder with a 2-stage valid/ready pipeline and armed error injection.
// Injection FSM:
//   state | meaning
//   IDLE  | no injection pending; accepted words get a clean tag
//   ARMED | latched mode/positions applied to the next accepted word
module ecc_encode_inject #(
  parameter int DW    = 64,
  parameter int CNT_W = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  ecc_encode_inject_if.slave   bus,
  input  logic [1:0]           inj_mode,
  input  logic [5:0]           inj_pos_a,
  input  logic [5:0]           inj_pos_b,
  input  logic                 inj_arm,
  input  logic                 inj_sticky,
  output logic                 inj_busy,
  output logic [CNT_W-1:0]     word_cnt,
  output logic [CNT_W-1:0]     inj_cnt
);

  typedef enum logic {IDLE, ARMED} state_t;

  typedef struct packed {
    logic [1:0] mode;
    logic [5:0] pos_a;
    logic [5:0] pos_b;
  } tag_t;

  state_t        state;
  tag_t          lat_tag;

  logic          s1_valid;
  logic [DW-1:0] s1_data;
  tag_t          s1_tag;
  logic          out_inj;

  logic          adv2;
  logic          acc;
  logic [DW-1:0] s2_data;
  logic [7:0]    s2_ecc;

  // Data bits fill the non-power-of-2 codeword positions 3,5,6,7,9,... in order.
  function automatic logic [7:0] ecc_calc(input logic [DW-1:0] d);
    logic [7:0] e;
    logic [6:0] di;
    e    = '0;
    di   = '0;
    e[0] = ^d;
    for (int p = 1; p < 72; p++) begin
      if ((p & (p - 1)) != 0) begin
        for (int k = 1; k < 8; k++) begin
          if (p[k-1]) e[k] = e[k] ^ d[di[5:0]];
        end
        di = di + 7'd1;
      end
    end
    return e;
  endfunction

  assign adv2         = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = !s1_valid || adv2;
  assign acc          = bus.in_valid && bus.in_ready;

  always_comb begin
    s2_data = s1_data;
    s2_ecc  = ecc_calc(s1_data);
    unique case (s1_tag.mode)
      2'b01:   s2_data = s1_data ^ (DW'(1) << s1_tag.pos_a);
      2'b10:   s2_data = s1_data ^ (DW'(1) << s1_tag.pos_a) ^ (DW'(1) << s1_tag.pos_b);
      2'b11:   s2_ecc  = s2_ecc ^ (8'd1 << s1_tag.pos_a[2:0]);
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid      <= 1'b0;
      s1_data       <= '0;
      s1_tag        <= '0;
      bus.out_valid <= 1'b0;
      bus.data_out  <= '0;
      bus.ecc_out   <= '0;
      out_inj       <= 1'b0;
      word_cnt      <= '0;
      inj_cnt       <= '0;
    end else begin
      if (acc) begin
        s1_valid <= 1'b1;
        s1_data  <= bus.data_in;
        s1_tag   <= (state == ARMED) ? lat_tag : '0;
      end else if (adv2) begin
        s1_valid <= 1'b0;
      end

      if (adv2) begin
        bus.out_valid <= s1_valid;
        if (s1_valid) begin
          bus.data_out <= s2_data;
          bus.ecc_out  <= s2_ecc;
          out_inj      <= (s1_tag.mode != 2'b00);
        end
      end

      if (acc) word_cnt <= word_cnt + CNT_W'(1);
      if (bus.out_valid && bus.out_ready && out_inj) inj_cnt <= inj_cnt + CNT_W'(1);
    end
  end

  // A new arm wins over consumption so it applies to the word after the one accepted now.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      lat_tag  <= '0;
      inj_busy <= 1'b0;
    end else begin
      if (inj_arm) begin
        state    <= ARMED;
        inj_busy <= 1'b1;
        lat_tag  <= '{mode: inj_mode, pos_a: inj_pos_a, pos_b: inj_pos_b};
      end else if (state == ARMED && acc && !inj_sticky) begin
        state    <= IDLE;
        inj_busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ecc_encode_inject.sv
// Directed bench for ecc_encode_inject: clean encodes, stalled stream, injection modes, reset.
module tb_ecc_encode_inject;

  logic        clock;
  logic        reset;
  logic [1:0]  inj_mode;
  logic [5:0]  inj_pos_a;
  logic [5:0]  inj_pos_b;
  logic        inj_arm;
  logic        inj_sticky;
  logic        inj_busy;
  logic [15:0] word_cnt;
  logic [15:0] inj_cnt;

  int total = 0;
  int bad   = 0;

  ecc_encode_inject_if #(.DW(64)) bus ();

  ecc_encode_inject #(.DW(64), .CNT_W(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .inj_mode   (inj_mode),
    .inj_pos_a  (inj_pos_a),
    .inj_pos_b  (inj_pos_b),
    .inj_arm    (inj_arm),
    .inj_sticky (inj_sticky),
    .inj_busy   (inj_busy),
    .word_cnt   (word_cnt),
    .inj_cnt    (inj_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // single-bit words 1<<k land at positions 3,5,6,7,9,10,11,12 -> ecc = (pos<<1)|1
  logic [7:0] stream_ecc [8] = '{8'h07, 8'h0B, 8'h0D, 8'h0F, 8'h13, 8'h15, 8'h17, 8'h19};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
  endtask

  task automatic send_one(input logic [63:0] d, input logic [63:0] exp_d, input logic [7:0] exp_e);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.data_in   = d;
    #1;
    chk("in_ready", bus.in_ready, 1);
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    chk("lat1_valid", bus.out_valid, 0);
    @(posedge clock); #1;
    chk("lat2_valid", bus.out_valid, 1);
    chk("data_out", bus.data_out, exp_d);
    chk("ecc_out", bus.ecc_out, exp_e);
    @(posedge clock); #1;
  endtask

  task automatic arm(input logic [1:0] m, input logic [5:0] a, input logic [5:0] b, input logic st);
    inj_arm    = 1'b1;
    inj_mode   = m;
    inj_pos_a  = a;
    inj_pos_b  = b;
    inj_sticky = st;
    @(posedge clock); #1;
    inj_arm = 1'b0;
  endtask

  initial begin
    int sent, recv;
    logic [63:0] held_d;
    logic [7:0]  held_e;

    reset = 1'b0;
    bus.in_valid = 1'b0; bus.data_in = '0; bus.out_ready = 1'b1;
    inj_mode = 2'b00; inj_pos_a = '0; inj_pos_b = '0; inj_arm = 1'b0; inj_sticky = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_data_out", bus.data_out, 0);
    chk("rst_ecc_out", bus.ecc_out, 0);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_inj_cnt", inj_cnt, 0);
    chk("rst_inj_busy", inj_busy, 0);
    reset = 1'b1;
    @(posedge clock); #1;

    send_one(64'd0, 64'd0, 8'h00);
    send_one(64'd1, 64'd1, 8'h07);
    send_one(64'd2, 64'd2, 8'h0B);
    chk("clean_word_cnt", word_cnt, 3);
    chk("clean_inj_cnt", inj_cnt, 0);

    arm(2'b01, 6'd0, 6'd0, 1'b0);
    chk("armed_busy", inj_busy, 1);
    send_one(64'd1, 64'd0, 8'h07);
    chk("m01_inj_cnt", inj_cnt, 1);
    chk("m01_busy_clear", inj_busy, 0);
    send_one(64'd2, 64'd2, 8'h0B);
    chk("after_m01_inj_cnt", inj_cnt, 1);

    arm(2'b10, 6'd0, 6'd1, 1'b0);
    send_one(64'd0, 64'd3, 8'h00);
    arm(2'b11, 6'd2, 6'd0, 1'b0);
    send_one(64'd0, 64'd0, 8'h04);
    chk("m10_m11_inj_cnt", inj_cnt, 3);

    arm(2'b10, 6'd7, 6'd7, 1'b0);
    send_one(64'd5, 64'd5, 8'h0A);
    chk("m10_same_pos_cnt", inj_cnt, 4);

    // 8-word stream with a 4-cycle downstream stall
    do_reset();
    sent = 0; recv = 0;
    held_d = '0; held_e = '0;
    for (int cyc = 0; cyc < 40 && recv < 8; cyc++) begin
      bus.in_valid  = (sent < 8);
      bus.data_in   = 64'd1 << sent;
      bus.out_ready = !(cyc >= 4 && cyc <= 7);
      @(negedge clock);
      if (cyc >= 4 && cyc <= 7) begin
        chk("stall_in_ready", bus.in_ready, 0);
        if (cyc == 4) begin
          held_d = bus.data_out;
          held_e = bus.ecc_out;
        end else begin
          chk("stall_data_hold", bus.data_out, held_d);
          chk("stall_ecc_hold", bus.ecc_out, held_e);
          chk("stall_valid_hold", bus.out_valid, 1);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("stream_data", bus.data_out, 64'd1 << recv);
        chk("stream_ecc", bus.ecc_out, stream_ecc[recv]);
        recv++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      @(posedge clock); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("stream_recv", recv, 8);
    chk("stream_word_cnt", word_cnt, 8);

    do_reset();
    arm(2'b01, 6'd5, 6'd0, 1'b1);
    send_one(64'h00, 64'h20, 8'h00);
    send_one(64'h20, 64'h00, 8'h15);
    send_one(64'h01, 64'h21, 8'h07);
    send_one(64'h02, 64'h22, 8'h0B);
    chk("sticky_inj_cnt", inj_cnt, 4);
    chk("sticky_word_cnt", word_cnt, 4);
    chk("sticky_busy", inj_busy, 1);

    // reset while a word is held at the output
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.data_in   = 64'd1;
    repeat (2) @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    chk("pre_rst_valid", bus.out_valid, 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_data", bus.data_out, 0);
    chk("mid_rst_ecc", bus.ecc_out, 0);
    chk("mid_rst_word_cnt", word_cnt, 0);
    chk("mid_rst_inj_cnt", inj_cnt, 0);
    chk("mid_rst_busy", inj_busy, 0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    send_one(64'd2, 64'd2, 8'h0B);
    chk("post_rst_word_cnt", word_cnt, 1);
    chk("post_rst_inj_cnt", inj_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ecc_encode_inject.md
Name: ecc_encode_inject

Overview:
- Upstream stage of the SECDED (72,64) checker; produces the `data_in` / `ecc_in` pair that the checker consumes.
- Encodes each accepted 64-bit word into 8 ECC bits through a 2-stage valid/ready pipeline.
- Can corrupt selected words (single data bit, double data bit, single ECC bit) so the checker's 00/10/11 flag paths are exercised.
- Keeps a count of accepted words and injected words.

Parameters:
- `DW`, 64, data width (fixed by the codeword map; other values unsupported)
- `CNT_W`, 16, width of the statistics counters

Ports:
- `clock`  in  1  rising-edge clock
- `reset`  in  1  asynchronous active-low reset
- `in_valid`  in  1  input word valid
- `in_ready`  out  1  stage 1 can accept
- `data_in`  in  64  raw data
- `out_valid`  out  1  encoded word valid
- `out_ready`  in  1  downstream accepts
- `data_out`  out  64  data after optional injection
- `ecc_out`  out  8  `{P7..P1, P0}`, computed on uncorrupted data
- `inj_mode`  in  2  00 none, 01 flip data bit `pos_a`, 10 flip data bits `pos_a` and `pos_b`, 11 flip `ecc_out` bit `pos_a[2:0]`
- `inj_pos_a`  in  6  first flip position
- `inj_pos_b`  in  6  second flip position
- `inj_arm`  in  1  one-cycle pulse; arms injection
- `inj_sticky`  in  1  1 = stay armed after use
- `inj_busy`  out  1  injection armed, not yet consumed
- `word_cnt`  out  `CNT_W`  words accepted at input
- `inj_cnt`  out  `CNT_W`  words emitted with injection applied

Behaviour:
- Reset (async, `reset`=0):
  - Clears both stage valids, `data_out`, `ecc_out`, both counters and `inj_busy`; state returns to IDLE.
  - An in-flight word is discarded.
- Codeword map:
  - Codeword positions 1..71.
  - Data bits 0..63 occupy the non-power-of-2 positions in ascending order (bit0 at 3, bit1 at 5, bit2 at 6, bit3 at 7, bit4 at 9, ...).
  - `P_k` (k=1..7) = XOR of data-bearing positions whose index has bit k-1 set.
  - `P0` = XOR of all 64 data bits.
  - `ecc_out[k]` = `P_k` for k=0..7.
- Pipeline:
  - Stage 1 registers `data_in` plus an injection tag when `in_valid && in_ready`.
  - Stage 2 computes ECC from the clean stage-1 data, applies the tag, and registers `data_out` / `ecc_out`.
  - Latency is 2 cycles from acceptance to `out_valid` with no stall; throughput is 1 word/cycle.
- Handshake:
  - Stage 2 advances when `!out_valid || out_ready`. Stage 1 advances into stage 2 under the same condition.
  - `in_ready` = `!s1_valid || stage-2 advance`.
  - `data_out`, `ecc_out` and `out_valid` stay stable while `out_valid && !out_ready`.
  - No combinational path from `in_valid` to `out_valid`.
- Injection FSM, states IDLE and ARMED:
  - IDLE → ARMED on `inj_arm`, latching `inj_mode`, `inj_pos_a` and `inj_pos_b`.
  - In ARMED, the next accepted word takes the latched tag. The FSM then returns to IDLE unless `inj_sticky`=1.
  - `inj_arm` while ARMED re-latches the fields.
  - `inj_arm` in the same cycle as an acceptance: the accepted word uses the previously latched state, and the new arm takes effect after it.
  - `inj_busy` = (state==ARMED).
  - A latched mode of 00 behaves as no injection.
- Flip rules:
  - Mode 10 with `pos_a`==`pos_b` flips nothing; the word still counts as injected.
  - Mode 11 flips only `ecc_out`; `data_out` is clean.
- Counters:
  - `word_cnt` increments on each input acceptance.
  - `inj_cnt` increments when a word with a non-00 tag transfers out (`out_valid && out_ready`).
  - Both wrap at 2^`CNT_W`; there is no saturation.

Test Plan:
- Encode clean words: `data_in` 0 → `ecc_out` 8'h00; `data_in` 1 → 8'h07; `data_in` 2 → 8'h0B. `out_valid` rises 2 cycles after acceptance.
- Back-to-back stream of 8 words with `out_ready` held 0 for 4 cycles mid-stream → no loss or duplication, outputs stable while stalled, `in_ready` low when both stages are full, `word_cnt`=8.
- Arm mode 01, `pos_a`=0, `inj_sticky`=0; send `data_in` 1 → `data_out`=0, `ecc_out`=8'h07, `inj_cnt`=1. The next word is clean and `inj_busy`=0.
- Arm mode 10, `pos_a`=0, `pos_b`=1; send 0 → `data_out`=3, `ecc_out`=8'h00. Arm mode 11, `pos_a`=2; send 0 → `data_out`=0, `ecc_out`=8'h04.
- `inj_sticky`=1, mode 01 → every subsequent word is flipped; `inj_cnt` equals `word_cnt` after draining.
- Assert reset mid-stream with `out_valid`=1 → `out_valid`, `data_out`, `ecc_out` and counters go to 0 immediately; `inj_busy`=0; the first word after release appears with latency 2.
